clk_en_gen: RTL and testbench

CLK_EN_GEN -- requirements
Module: clk_en_gen

---
 rtl/clk_en_gen.sv | 115 +++++++++++
 tb/tb_clk_en_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator with a settle (lock) delay.
// Each channel emits a one-cycle enable every N cycles, phase-aligned at lock exit.
module clk_en_gen #(
  parameter int CHANNELS    = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_n_i,
  input  logic [CHANNELS*DIV_WIDTH-1:0] div_i,
  input  logic                          load_i,
  output logic                          ready_o,
  output logic [CHANNELS-1:0]           clk_en_o,
  output logic                          sync_o
);

  localparam int CW = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  localparam logic [0:0] S_LOCK = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [CHANNELS-1:0] en_q, en_d;

  logic [DIV_WIDTH-1:0] ratio_q [CHANNELS];
  logic [DIV_WIDTH-1:0] ratio_d [CHANNELS];
  logic [DIV_WIDTH-1:0] phase_q [CHANNELS];
  logic [DIV_WIDTH-1:0] phase_d [CHANNELS];
  logic [DIV_WIDTH-1:0] last    [CHANNELS];

  logic [CHANNELS-1:0] wrap;
  logic                lock_done;
  logic                step;

  // Ratio 0 behaves as ratio 1, so the last phase is 0 in both cases.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      last[c] = (ratio_q[c] == '0) ? '0 : ratio_q[c] - ONE;
      wrap[c] = (phase_q[c] == last[c]);
    end
  end

  assign lock_done = (state_q == S_LOCK) &&
                     ((cnt_q + CNT_ONE) == LOCK_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    en_d    = en_q;
    ratio_d = ratio_q;
    phase_d = phase_q;
    step    = 1'b0;
    if (load_i) begin
      state_d = S_LOCK;
      cnt_d   = '0;
      ready_d = 1'b0;
      en_d    = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        ratio_d[c] = div_i[c*DIV_WIDTH +: DIV_WIDTH];
        phase_d[c] = '0;
      end
    end else if (state_q == S_LOCK) begin
      if (lock_done) begin
        state_d = S_RUN;
        cnt_d   = '0;
        ready_d = 1'b1;
        step    = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      step = 1'b1;
    end
    // Phase is 0 at lock exit, so edge R is simply the first step.
    if (step) begin
      for (int c = 0; c < CHANNELS; c++) begin
        en_d[c]    = wrap[c];
        phase_d[c] = wrap[c] ? '0 : phase_q[c] + ONE;
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q <= S_LOCK;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      en_q    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        ratio_q[c] <= ONE;
        phase_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      for (int c = 0; c < CHANNELS; c++) begin
        ratio_q[c] <= ratio_d[c];
        phase_q[c] <= phase_d[c];
      end
    end
  end

  assign ready_o  = ready_q;
  assign clk_en_o = en_q;
  assign sync_o   = &en_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed self-checking bench for clk_en_gen (2 channels, 8-bit ratios).
// Each task drives one scenario and checks outputs 1ns after each edge.
module tb_clk_en_gen;

  logic        clk;
  logic        rst_n;
  logic [15:0] div;
  logic        load;
  logic        ready;
  logic [1:0]  en;
  logic        sync;

  int n_checks = 0;
  int n_fail   = 0;

  clk_en_gen #(
    .CHANNELS(2),
    .DIV_WIDTH(8),
    .LOCK_CYCLES(16)
  ) dut (
    .sys_clk_i(clk),
    .sys_rst_n_i(rst_n),
    .div_i(div),
    .load_i(load),
    .ready_o(ready),
    .clk_en_o(en),
    .sync_o(sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    n_checks++;
    if (ready !== 1'b0 || en !== 2'b00 || sync !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: ready=%b en=%b sync=%b, want 0/00/0",
               tag, ready, en, sync);
    end
  endtask

  task automatic do_load(input logic [7:0] c0, input logic [7:0] c1);
    div  = {c1, c0};
    load = 1'b1;
    tick();
    load = 1'b0;
    chk_idle("load_edge");
  endtask

  // 16 edges of lock; returns just after edge R.
  task automatic wait_lock(input string tag);
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_checks++;
      if (ready !== (k == 16)) begin
        n_fail++;
        $display("FAIL %s_ready k=%0d: ready=%b want %b",
                 tag, k, ready, (k == 16));
      end
      if (k < 16) chk_idle("lock_hold");
    end
  endtask

  // Called just after edge R; checks offsets t=0..len-1.
  task automatic check_run(input string tag, input int n0,
                           input int n1, input int len);
    logic [1:0] exp;
    for (int t = 0; t < len; t++) begin
      if (t > 0) tick();
      exp[0] = ((t + 1) % n0 == 0);
      exp[1] = ((t + 1) % n1 == 0);
      n_checks++;
      if (en !== exp || sync !== (&exp) || ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s t=%0d: en=%b sync=%b ready=%b want %b/%b/1",
                 tag, t, en, sync, ready, exp, &exp);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    chk_idle("reset_async");
    tick();
    tick();
    chk_idle("reset_held");
    #3 rst_n = 1'b1;
    #1;
    wait_lock("reset");
    check_run("defaults", 1, 1, 6);
  endtask

  task automatic test_ratio_3_4();
    do_load(8'd3, 8'd4);
    div = 16'hFFFF;
    wait_lock("r34");
    check_run("r34", 3, 4, 25);
  endtask

  task automatic test_wrap();
    do_load(8'd0, 8'd255);
    wait_lock("wrap");
    check_run("wrap", 1, 255, 512);
  endtask

  task automatic test_reload_mid_lock();
    do_load(8'd3, 8'd4);
    for (int k = 0; k < 10; k++) tick();
    do_load(8'd5, 8'd6);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_idle("reload_gap");
    end
    do_load(8'd2, 8'd1);
    wait_lock("reload");
    check_run("reload", 2, 1, 5);
  endtask

  task automatic test_load_held();
    logic [7:0] seq [5];
    seq[0] = 8'd5;
    seq[1] = 8'd6;
    seq[2] = 8'd7;
    seq[3] = 8'd8;
    seq[4] = 8'd3;
    load = 1'b1;
    for (int k = 0; k < 5; k++) begin
      div = {8'd2, seq[k]};
      tick();
      chk_idle("held");
    end
    load = 1'b0;
    wait_lock("held");
    check_run("held", 3, 2, 8);
  endtask

  task automatic test_lock_priority();
    do_load(8'd1, 8'd1);
    for (int k = 0; k < 15; k++) tick();
    chk_idle("prio_pre");
    do_load(8'd4, 8'd2);
    wait_lock("prio");
    check_run("prio", 4, 2, 6);
  endtask

  task automatic test_reset_mid_run();
    do_load(8'd3, 8'd3);
    wait_lock("rrun");
    check_run("rrun", 3, 3, 3);
    #3 rst_n = 1'b0;
    #1;
    chk_idle("rrun_async");
    #1 rst_n = 1'b1;
    #1;
    chk_idle("rrun_release");
    wait_lock("rrun_after");
    check_run("rrun_ratio1", 1, 1, 4);
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    div   = '0;
    test_reset();
    test_ratio_3_4();
    test_wrap();
    test_reload_mid_lock();
    test_load_held();
    test_lock_priority();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
